// File: rtl/game_countdown_timer.sv
// Game countdown clock: counts a BCD seconds value down to 00 at one step per
// CLOCK_FREQUENCY cycles, with start/pause, bonus time, low-time warning and expiry.
module game_countdown_timer #(
   parameter int CLOCK_FREQUENCY = 50000000,
   parameter int START_SECONDS   = 60,
   parameter int WARN_SECONDS    = 10,
   parameter int BONUS_SECONDS   = 5
) (
   input  logic       ClockIn,
   input  logic       Reset,
   input  logic       Load,
   input  logic [3:0] LoadTens,
   input  logic [3:0] LoadOnes,
   input  logic       Start,
   input  logic       Pause,
   input  logic       BonusAdd,
   output logic [3:0] OnesValue,
   output logic [3:0] TensValue,
   output logic       Running,
   output logic       Warning,
   output logic       TimeUp,
   output logic       Expired,
   output logic [1:0] DebugState
);

   // Control inputs are single-cycle pulses sampled on the rising ClockIn edge;
   // there is no back-pressure, every pulse is acted on (or ignored) in the cycle it is seen.

   localparam int DIV_W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLOCK_FREQUENCY - 1);
   localparam logic [3:0] START_TENS = 4'(START_SECONDS / 10);
   localparam logic [3:0] START_ONES = 4'(START_SECONDS % 10);
   localparam logic [3:0] BONUS_TENS = 4'(BONUS_SECONDS / 10);
   localparam logic [3:0] BONUS_ONES = 4'(BONUS_SECONDS % 10);
   localparam logic [6:0] WARN_BIN   = 7'(WARN_SECONDS);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUNNING = 2'd1,
      S_PAUSED  = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       ones_q, ones_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             running_q, running_d;
   logic             warning_q, warning_d;
   logic             time_up_q, time_up_d;
   logic             expired_q, expired_d;

   logic             tick;
   logic [7:0]       dec_val;
   logic [7:0]       bonus_val;
   logic [6:0]       bin_d;

   function automatic logic [3:0] clamp9(input logic [3:0] d);
      clamp9 = (d > 4'd9) ? 4'd9 : d;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0) bcd_dec = {v[7:4] - 4'd1, 4'd9};
      else                bcd_dec = {v[7:4], v[3:0] - 4'd1};
   endfunction

   // BCD add of the bonus with decimal carry, saturating at 99.
   function automatic logic [7:0] bcd_add_sat(input logic [7:0] v);
      logic [4:0] o;
      logic [4:0] t;
      logic       c;
      o = {1'b0, v[3:0]} + {1'b0, BONUS_ONES};
      c = (o > 5'd9);
      if (c) o = o - 5'd10;
      t = {1'b0, v[7:4]} + {1'b0, BONUS_TENS} + {4'd0, c};
      if (t > 5'd9) bcd_add_sat = 8'h99;
      else          bcd_add_sat = {t[3:0], o[3:0]};
   endfunction

   assign tick      = (state_q == S_RUNNING) && (div_q == '0);
   assign dec_val   = bcd_dec({tens_q, ones_q});
   assign bonus_val = bcd_add_sat(tick ? dec_val : {tens_q, ones_q});

   always_comb begin
      state_d   = state_q;
      tens_d    = tens_q;
      ones_d    = ones_q;
      div_d     = div_q;
      time_up_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Load) begin
               tens_d = clamp9(LoadTens);
               ones_d = clamp9(LoadOnes);
            end else if (Start && ({tens_q, ones_q} != 8'h00)) begin
               state_d = S_RUNNING;
               div_d   = DIV_RELOAD;
            end
         end
         S_RUNNING: begin
            div_d = tick ? DIV_RELOAD : div_q - 1'b1;
            if (BonusAdd) begin
               {tens_d, ones_d} = bonus_val;
            end else if (tick) begin
               {tens_d, ones_d} = dec_val;
            end
            // A coinciding bonus always leaves time on the clock, so only a bare tick expires.
            if (tick && !BonusAdd && (dec_val == 8'h00)) begin
               state_d   = S_EXPIRED;
               time_up_d = 1'b1;
            end else if (Pause) begin
               state_d = S_PAUSED;
            end
         end
         S_PAUSED: begin
            if (BonusAdd) {tens_d, ones_d} = bonus_val;
            if (Pause) state_d = S_RUNNING;
         end
         S_EXPIRED: begin
            if (Load) begin
               tens_d  = clamp9(LoadTens);
               ones_d  = clamp9(LoadOnes);
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      bin_d     = 7'(tens_d) * 7'd10 + 7'(ones_d);
      running_d = (state_d == S_RUNNING);
      expired_d = (state_d == S_EXPIRED);
      warning_d = ((state_d == S_RUNNING) || (state_d == S_PAUSED)) && (bin_d <= WARN_BIN);
   end

   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         tens_q    <= START_TENS;
         ones_q    <= START_ONES;
         div_q     <= DIV_RELOAD;
         running_q <= 1'b0;
         warning_q <= 1'b0;
         time_up_q <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         div_q     <= div_d;
         running_q <= running_d;
         warning_q <= warning_d;
         time_up_q <= time_up_d;
         expired_q <= expired_d;
      end
   end

   assign TensValue  = tens_q;
   assign OnesValue  = ones_q;
   assign Running    = running_q;
   assign Warning    = warning_q;
   assign TimeUp     = time_up_q;
   assign Expired    = expired_q;
   assign DebugState = state_q;

endmodule
